uart_rx_data_sampling: RTL and testbench
========================================

Name: uart_rx_data_sampling

Overview:
- Oversampling front end of the UART receiver. It sits directly upstream of the deserializer.
- Synchronises RX_IN and counts oversampling edges and bit positions within a frame.
- Majority-votes three mid-bit samples and delivers one sampled_bit per bit period, with a one-cycle sample_valid strobe.
- Also flags a false start bit, so the RX FSM can abort.

Parameters:
- DATA_WIDTH, 8: data bits per frame.
- SYNC_STAGES, 2: number of RX_IN synchroniser flops (minimum 2).

Ports:
- clk  input  1: receiver clock, equal to the oversampling clock.
- rst_n  input  1: asynchronous, active-low reset.
- RX_IN  input  1: raw serial line, idle high.
- enable  input  1: from the RX FSM; high for the duration of a frame, starting on the start-bit falling edge.
- prescale  input  6: oversampling ratio; legal values are 8, 16 and 32.
- par_en  input  1: a parity bit is present in the frame.
- sampled_bit  output  1: majority-voted value of the current bit.
- sample_valid  output  1: one-cycle strobe; sampled_bit is valid for this bit.
- edge_cnt  output  6: oversampling edge index within the current bit.
- bit_cnt  output  4: bit index within the frame; 0 is the start bit.
- start_glitch  output  1: one-cycle pulse when the start bit samples high.
- frame_done  output  1: one-cycle pulse on the last edge of the stop bit.

Behaviour:
- Reset values: all outputs 0, except sampled_bit, which resets to 1 (idle). Synchroniser flops reset to 1.
- Synchroniser: RX_IN passes through SYNC_STAGES flops. All sampling uses the synchronised value rx_s.
- prescale latching:
  - Latched into ps_q on the cycle enable rises (0 to 1).
  - A value outside {8,16,32} is latched as 8.
  - ps_q is held stable while enable is high.
- Frame length: FRAME_BITS = 1 + DATA_WIDTH + par_en + 1. par_en is latched together with prescale.
- Edge counter:
  - While enable is high, edge_cnt increments every clk.
  - When edge_cnt == ps_q-1, it wraps to 0 and bit_cnt increments.
- Bit counter: on the wrap at bit_cnt == FRAME_BITS-1, bit_cnt returns to 0 and frame_done pulses in that same cycle.
- Sampling: with h = ps_q/2, rx_s is captured into s0, s1, s2 at edge_cnt = h-1, h and h+1 respectively.
- Vote:
  - In the cycle after the s2 capture (edge_cnt == h+2), sampled_bit <= majority(s0,s1,s2) and sample_valid = 1 for exactly that cycle.
  - Latency from the third sample to the strobe is 1 clk.
- Strobe count: exactly one sample_valid per bit period, i.e. FRAME_BITS strobes per frame.
- start_glitch: asserted together with the sample_valid of bit_cnt == 0 when the vote result is 1. The block keeps counting; the FSM decides whether to drop enable.
- enable low, including deassertion mid-bit:
  - On the next clk, edge_cnt, bit_cnt, s0, s1 and s2 clear to 0.
  - No sample_valid or frame_done is generated.
  - sampled_bit holds its last value.
- enable re-asserted in the same cycle it would have wrapped: this is not possible. Re-assertion always starts from edge_cnt = 0, bit_cnt = 0.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). The first frame after reset release requires a new enable rising edge.
- Widths: edge_cnt is 6 bits, enough for prescale 32 (values 0..31). bit_cnt is 4 bits, covering a maximum of 11 bits at DATA_WIDTH=8. There is no overflow path.

Decomposition:
- Shared package uart_rx_pkg holds:
  - PRESCALE_8/16/32 constants;
  - FRAME_BITS function of DATA_WIDTH and par_en;
  - IDLE_LEVEL = 1'b1.
- One natural sub-module: uart_rx_sync, the parameterised SYNC_STAGES flop chain with reset-to-1.
- Majority vote stays inline.

Test Plan:
- Nominal frame, prescale=8, par_en=0, data 0xA5 sent LSB-first at 8 clk/bit:
  - required: 10 sample_valid strobes at edge_cnt=6 of each bit;
  - sampled_bit sequence 0,1,0,1,0,0,1,0,1,1;
  - frame_done at bit_cnt=9, edge_cnt=7.
- prescale=16 and prescale=32, par_en=1, data 0x3C with even parity:
  - required: 11 strobes, each at edge_cnt=10 (prescale 16) or 18 (prescale 32);
  - parity bit sampled 0.
- Single-edge glitch on RX_IN forced opposite at edge_cnt=h, prescale=16: majority still yields the correct bit; no error.
- Start bit high for edges h-1..h+1 (false start): start_glitch=1 with the bit-0 sample_valid; sampled_bit=1.
- Illegal prescale=12 latched at enable rise: behaves as 8 (strobe at edge_cnt=6); changing prescale mid-frame to 32 has no effect.
- enable dropped at bit_cnt=4, edge_cnt=3, then rst_n pulsed mid-frame on a second frame:
  - required: counters 0 the next clk with no further strobes;
  - after reset, sampled_bit=1 and all other outputs 0 immediately.

Source files
------------

// File: rtl/uart_rx_data_sampling_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
//   Shared constants and helpers for the UART receive oversampling front end.
//   - PRESCALE_8/16/32 : the legal oversampling ratios
//   - IDLE_LEVEL       : level of an idle serial line
//   - frame_bits()     : start + data + optional parity + stop
//   - legal_prescale() : maps any unsupported ratio onto PRESCALE_8
// ---------------------------------------------------------------------------
package uart_rx_pkg;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;
  localparam logic       IDLE_LEVEL  = 1'b1;

  function automatic logic [3:0] frame_bits(input int unsigned data_width,
                                            input logic        par_en);
    return 4'(data_width + 2) + {3'b000, par_en};
  endfunction

  function automatic logic [5:0] legal_prescale(input logic [5:0] ps);
    return (ps == PRESCALE_16 || ps == PRESCALE_32) ? ps : PRESCALE_8;
  endfunction

endpackage

// File: rtl/uart_rx_data_sampling_if.sv
// ---------------------------------------------------------------------------
// uart_rx_data_sampling_if
//   Connection between the RX FSM (master) and the oversampling front end
//   (slave).
//   master drives : enable, prescale, par_en
//   slave drives  : sampled_bit, sample_valid, edge_cnt, bit_cnt,
//                   start_glitch, frame_done
//
// Handshake: sample_valid is a one-cycle valid strobe with no ready. The
// consumer must take sampled_bit in the cycle sample_valid is high; there is
// no back-pressure, and the value after the strobe is merely held, not
// re-announced. start_glitch and frame_done are plain one-cycle pulses.
// ---------------------------------------------------------------------------
interface uart_rx_data_sampling_if;

  logic       enable;
  logic [5:0] prescale;
  logic       par_en;
  logic       sampled_bit;
  logic       sample_valid;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       start_glitch;
  logic       frame_done;

  modport master (
    output enable, prescale, par_en,
    input  sampled_bit, sample_valid, edge_cnt, bit_cnt, start_glitch, frame_done
  );

  modport slave (
    input  enable, prescale, par_en,
    output sampled_bit, sample_valid, edge_cnt, bit_cnt, start_glitch, frame_done
  );

endinterface

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
//   STAGES-deep flop chain bringing the asynchronous serial line into the clk
//   domain. Flops reset to the idle line level so reset never looks like a
//   start bit.
//   clk, rst_n : clock, asynchronous active-low reset
//   rx_in      : raw serial line
//   rx_s       : synchronised line
// ---------------------------------------------------------------------------
module uart_rx_sync
  import uart_rx_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_in,
  output logic rx_s
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], rx_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {STAGES{IDLE_LEVEL}};
    else        sync_q <= sync_d;
  end

  assign rx_s = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_data_sampling.sv
// ---------------------------------------------------------------------------
// uart_rx_data_sampling
//   Oversampling front end of the UART receiver. Counts oversampling edges and
//   bit positions while enable is high, captures three mid-bit samples and
//   presents their majority vote once per bit with a one-cycle sample_valid.
//   clk, rst_n : oversampling clock, asynchronous active-low reset
//   RX_IN      : raw serial line (idle high)
//   bus        : slave side of uart_rx_data_sampling_if
// ---------------------------------------------------------------------------
module uart_rx_data_sampling
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          RX_IN,
  uart_rx_data_sampling_if.slave        bus
);

  logic rx_s;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_in (RX_IN),
    .rx_s  (rx_s)
  );

  logic       en_q, en_d;
  logic [5:0] ps_q, ps_d;
  logic       par_q, par_d;
  logic [5:0] edge_cnt_q, edge_cnt_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       s0_q, s0_d;
  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       sampled_bit_q, sampled_bit_d;

  logic [5:0] half;
  logic       at_last_edge;
  logic       at_last_bit;
  logic       vote;
  logic       strobe;

  // ps_q/par_q are safe to use even on the enable-rise cycle: edge_cnt is 0
  // there, which never matches a sample point or the last edge.
  always_comb begin
    half         = ps_q >> 1;
    at_last_edge = (edge_cnt_q == ps_q - 6'd1);
    at_last_bit  = (bit_cnt_q == frame_bits(DATA_WIDTH, par_q) - 4'd1);
    vote         = (s0_q & s1_q) | (s0_q & s2_q) | (s1_q & s2_q);
    // edge_cnt only reaches h+2 by counting, so s0..s2 are fresh here.
    strobe       = (edge_cnt_q == half + 6'd2);
  end

  always_comb begin
    en_d          = bus.enable;
    ps_d          = ps_q;
    par_d         = par_q;
    edge_cnt_d    = edge_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    s0_d          = s0_q;
    s1_d          = s1_q;
    s2_d          = s2_q;
    sampled_bit_d = strobe ? vote : sampled_bit_q;

    if (bus.enable && !en_q) begin
      ps_d  = legal_prescale(bus.prescale);
      par_d = bus.par_en;
    end

    if (bus.enable) begin
      if (at_last_edge) begin
        edge_cnt_d = 6'd0;
        bit_cnt_d  = at_last_bit ? 4'd0 : bit_cnt_q + 4'd1;
      end else begin
        edge_cnt_d = edge_cnt_q + 6'd1;
      end
      if (edge_cnt_q == half - 6'd1) s0_d = rx_s;
      if (edge_cnt_q == half)        s1_d = rx_s;
      if (edge_cnt_q == half + 6'd1) s2_d = rx_s;
    end else begin
      edge_cnt_d = 6'd0;
      bit_cnt_d  = 4'd0;
      s0_d       = 1'b0;
      s1_d       = 1'b0;
      s2_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q          <= 1'b0;
      ps_q          <= PRESCALE_8;
      par_q         <= 1'b0;
      edge_cnt_q    <= 6'd0;
      bit_cnt_q     <= 4'd0;
      s0_q          <= 1'b0;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      sampled_bit_q <= IDLE_LEVEL;
    end else begin
      en_q          <= en_d;
      ps_q          <= ps_d;
      par_q         <= par_d;
      edge_cnt_q    <= edge_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      s0_q          <= s0_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      sampled_bit_q <= sampled_bit_d;
    end
  end

  // The vote is forwarded during the strobe cycle so sampled_bit is valid
  // together with sample_valid; afterwards the registered copy holds it.
  assign bus.sampled_bit  = strobe ? vote : sampled_bit_q;
  assign bus.sample_valid = strobe;
  assign bus.edge_cnt     = edge_cnt_q;
  assign bus.bit_cnt      = bit_cnt_q;
  assign bus.start_glitch = strobe && (bit_cnt_q == 4'd0) && vote;
  assign bus.frame_done   = bus.enable && at_last_edge && at_last_bit;

endmodule

// File: tb/tb_uart_rx_data_sampling.sv
module tb_uart_rx_data_sampling;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic rx_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_rx_data_sampling_if bus ();

  uart_rx_data_sampling #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RX_IN (rx_in),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int   n_cmp;
  int   n_err;
  logic model_sb;      // last voted bit the line should be showing
  logic obs_val[$];    // sampled_bit seen at each strobe of the last frame
  int   obs_edge[$];   // edge_cnt seen at each strobe of the last frame

  // ---------------- driver: idle ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.enable = 1'b0;
      rx_in      = 1'b1;
    end
  endtask

  // ---------------- driver + reference model: one frame ----------------
  // The reference works from the frame's bit list: bit b occupies line cycles
  // b*p .. b*p+p-1, a sample at edge e is taken two cycles (synchroniser)
  // after the line value, the strobe appears at edge h+2 and carries the
  // value the majority of three samples must produce.
  task automatic run_frame(input int ps_drive, input int ps_mid, input bit par,
                           input logic [7:0] data, input int glitch_pt,
                           input bit false_start, input int stop_at);
    int   p, h, fb, stop, total, idx;
    int   ee, eb;
    bit   esv, efd, esg;
    logic ev;
    logic bits[$];
    logic line[$];
    logic [0:0] exp_q[$];

    p  = (ps_drive == 16 || ps_drive == 32) ? ps_drive : 8;
    h  = p / 2;
    fb = 10 + int'(par);

    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (par) bits.push_back(^data);
    bits.push_back(1'b1);

    for (int b = 0; b < fb; b++) begin
      ev = (false_start && b == 0) ? 1'b1 : bits[b];
      exp_q.push_back(ev);
      for (int e = 0; e < p; e++) line.push_back(bits[b]);
    end
    if (glitch_pt >= 0) begin
      for (int b = 0; b < fb; b++) begin
        idx = b * p + h - 3 + glitch_pt;
        line[idx] = ~line[idx];
      end
    end
    if (false_start) begin
      for (int k = h - 3; k <= h - 1; k++) line[k] = 1'b1;
    end

    stop  = (stop_at < 0) ? fb * p : stop_at;
    total = stop + 6;
    obs_val.delete();
    obs_edge.delete();

    for (int c = 0; c < total; c++) begin
      @(posedge clk);
      #1;
      bus.enable   = (c < stop);
      rx_in        = (c < stop) ? line[c] : 1'b1;
      bus.prescale = (c == 0) ? 6'(ps_drive) : 6'(ps_mid);
      bus.par_en   = (c == 0) ? par : ~par;
      @(negedge clk);

      if (c <= stop) begin
        ee  = c % p;
        eb  = (c / p) % fb;
        esv = (ee == h + 2) && (c / p < fb);
        efd = (c < stop) && (c == fb * p - 1);
      end else begin
        ee = 0; eb = 0; esv = 1'b0; efd = 1'b0;
      end
      esg = 1'b0;
      if (esv) begin
        ev       = exp_q.pop_front();
        model_sb = ev;
        esg      = (c / p == 0) && ev;
      end

      if (bus.sample_valid) begin
        obs_val.push_back(bus.sampled_bit);
        obs_edge.push_back(int'(bus.edge_cnt));
      end

      n_cmp++;
      if (bus.edge_cnt !== 6'(ee)) begin
        n_err++;
        $display("FAIL edge_cnt c=%0d: got %0d want %0d", c, bus.edge_cnt, ee);
      end
      n_cmp++;
      if (bus.bit_cnt !== 4'(eb)) begin
        n_err++;
        $display("FAIL bit_cnt c=%0d: got %0d want %0d", c, bus.bit_cnt, eb);
      end
      n_cmp++;
      if (bus.sample_valid !== esv) begin
        n_err++;
        $display("FAIL sample_valid c=%0d: got %0b want %0b", c, bus.sample_valid, esv);
      end
      n_cmp++;
      if (bus.sampled_bit !== model_sb) begin
        n_err++;
        $display("FAIL sampled_bit c=%0d: got %0b want %0b", c, bus.sampled_bit, model_sb);
      end
      n_cmp++;
      if (bus.frame_done !== efd) begin
        n_err++;
        $display("FAIL frame_done c=%0d: got %0b want %0b", c, bus.frame_done, efd);
      end
      n_cmp++;
      if (bus.start_glitch !== esg) begin
        n_err++;
        $display("FAIL start_glitch c=%0d: got %0b want %0b", c, bus.start_glitch, esg);
      end
    end

    if (stop_at < 0) begin
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_err++;
        $display("FAIL strobes_missing: got %0d left want 0", exp_q.size());
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if (bus.sampled_bit !== 1'b1 || bus.sample_valid !== 1'b0 || bus.edge_cnt !== 6'd0 ||
        bus.bit_cnt !== 4'd0 || bus.start_glitch !== 1'b0 || bus.frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got sb=%0b sv=%0b e=%0d b=%0d sg=%0b fd=%0b want sb=1 rest 0",
               tag, bus.sampled_bit, bus.sample_valid, bus.edge_cnt, bus.bit_cnt,
               bus.start_glitch, bus.frame_done);
    end
  endtask

  task automatic test_reset;
    rst_n        = 1'b0;
    rx_in        = 1'b1;
    bus.enable   = 1'b0;
    bus.prescale = 6'd8;
    bus.par_en   = 1'b0;
    model_sb     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_values");
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    @(negedge clk);
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_nominal;
    logic nom_seq [10];
    nom_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    run_frame(8, 8, 1'b0, 8'hA5, -1, 1'b0, -1);
    n_cmp++;
    if (obs_val.size() != 10) begin
      n_err++;
      $display("FAIL nominal_strobe_count: got %0d want 10", obs_val.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_cmp++;
        if (obs_val[i] !== nom_seq[i] || obs_edge[i] != 6) begin
          n_err++;
          $display("FAIL nominal_bit%0d: got %0b@%0d want %0b@6", i, obs_val[i], obs_edge[i], nom_seq[i]);
        end
      end
    end
    idle(2);
  endtask

  task automatic test_parity;
    int ps_list [2];
    ps_list = '{16, 32};
    foreach (ps_list[k]) begin
      run_frame(ps_list[k], ps_list[k], 1'b1, 8'h3C, -1, 1'b0, -1);
      n_cmp++;
      if (obs_val.size() != 11) begin
        n_err++;
        $display("FAIL parity_strobe_count ps=%0d: got %0d want 11", ps_list[k], obs_val.size());
      end else begin
        n_cmp++;
        if (obs_val[9] !== 1'b0) begin
          n_err++;
          $display("FAIL parity_bit ps=%0d: got %0b want 0", ps_list[k], obs_val[9]);
        end
        foreach (obs_edge[i]) begin
          n_cmp++;
          if (obs_edge[i] != ps_list[k] / 2 + 2) begin
            n_err++;
            $display("FAIL parity_edge ps=%0d bit%0d: got %0d want %0d", ps_list[k], i, obs_edge[i], ps_list[k] / 2 + 2);
          end
        end
      end
      idle(2);
    end
  endtask

  task automatic test_glitch;
    run_frame(16, 16, 1'b0, 8'($urandom_range(0, 255)), 1, 1'b0, -1);
    idle(2);
  endtask

  task automatic test_false_start;
    run_frame(16, 16, 1'b0, 8'($urandom_range(0, 255)), -1, 1'b1, -1);
    n_cmp++;
    if (obs_val.size() == 0 || obs_val[0] !== 1'b1) begin
      n_err++;
      $display("FAIL false_start_bit0: got %0d strobes/%0b want bit0=1",
               obs_val.size(), (obs_val.size() != 0) ? obs_val[0] : 1'bx);
    end
    idle(2);
  endtask

  task automatic test_illegal_prescale;
    run_frame(12, 32, 1'b0, 8'($urandom_range(0, 255)), -1, 1'b0, -1);
    n_cmp++;
    if (obs_edge.size() != 10) begin
      n_err++;
      $display("FAIL illegal_ps_count: got %0d want 10", obs_edge.size());
    end else begin
      foreach (obs_edge[i]) begin
        n_cmp++;
        if (obs_edge[i] != 6) begin
          n_err++;
          $display("FAIL illegal_ps_edge bit%0d: got %0d want 6", i, obs_edge[i]);
        end
      end
    end
    idle(2);
  endtask

  task automatic test_enable_drop;
    run_frame(8, 8, 1'b0, 8'($urandom_range(0, 255)), -1, 1'b0, 4 * 8 + 3);
    n_cmp++;
    if (obs_val.size() != 4) begin
      n_err++;
      $display("FAIL drop_strobe_count: got %0d want 4", obs_val.size());
    end
    idle(2);
  endtask

  task automatic test_reset_mid_frame;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      bus.enable   = 1'b1;
      bus.prescale = 6'd16;
      bus.par_en   = 1'b0;
      rx_in        = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if (bus.edge_cnt !== 6'd7 || bus.bit_cnt !== 4'd2 || bus.sampled_bit !== 1'b0) begin
      n_err++;
      $display("FAIL pre_reset_state: got e=%0d b=%0d sb=%0b want e=7 b=2 sb=0",
               bus.edge_cnt, bus.bit_cnt, bus.sampled_bit);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_frame");
    bus.enable = 1'b0;
    rx_in      = 1'b1;
    model_sb   = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    run_frame(16, 16, 1'b0, 8'($urandom_range(0, 255)), -1, 1'b0, -1);
    idle(2);
  endtask

  task automatic test_random;
    int ps_opts [3];
    int ps, gp;
    ps_opts = '{8, 16, 32};
    for (int n = 0; n < 6; n++) begin
      ps = ps_opts[$urandom_range(0, 2)];
      gp = int'($urandom_range(0, 3)) - 1;
      run_frame(ps, ps_opts[$urandom_range(0, 2)], 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)), gp, 1'b0, -1);
      idle($urandom_range(1, 4));
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_nominal();
    test_parity();
    test_glitch();
    test_false_start();
    test_illegal_prescale();
    test_enable_drop();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
